// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the RV32I datapath.
// master = controller side, slave = datapath side.
// RETIRE_COUNTER_EN adds the 64-bit instret counter output.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_we;
  logic       pc_we;
  logic       pc_sel;
  logic [1:0] opa_sel;
  logic       opb_sel;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       trap;
  logic [1:0] trap_cause;
`ifdef RETIRE_COUNTER_EN
  logic [63:0] instret;
`endif

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
    output opa_sel, opb_sel, reg_we, wb_sel, trap, trap_cause
`ifdef RETIRE_COUNTER_EN
    , output instret
`endif
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
    input  opa_sel, opb_sel, reg_we, wb_sel, trap, trap_cause
`ifdef RETIRE_COUNTER_EN
    , input instret
`endif
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP.
// Outputs are combinational from the registered state plus opcode and the
// ready/branch inputs. A per-state wait counter traps on stuck memory requests.
// Optional: define RETIRE_COUNTER_EN to add the 64-bit instret retire counter.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controller_if.master  bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;
  localparam logic [1:0] CAUSE_SYS = 2'b11;

  // Counter must hold MEM_TIMEOUT itself; keep one bit when timeouts are off.
  localparam int          CW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);
  localparam bit          TMO_EN = (MEM_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic [1:0]    cause_q, cause_d;
  logic          retire;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
  logic is_store, is_opimm, is_op, is_fence, is_system, legal;
  logic req_wait, timeout;
  logic [1:0] opa_x;
  logic       opb_x;

  // Opcode class decode and the EXECUTE operand selects for that class
  always_comb begin
    is_lui    = (bus.opcode == OP_LUI);
    is_auipc  = (bus.opcode == OP_AUIPC);
    is_jal    = (bus.opcode == OP_JAL);
    is_jalr   = (bus.opcode == OP_JALR);
    is_branch = (bus.opcode == OP_BRANCH);
    is_load   = (bus.opcode == OP_LOAD);
    is_store  = (bus.opcode == OP_STORE);
    is_opimm  = (bus.opcode == OP_OPIMM);
    is_op     = (bus.opcode == OP_OP);
    is_fence  = (bus.opcode == OP_FENCE);
    is_system = (bus.opcode == OP_SYSTEM);
    legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                is_store | is_opimm | is_op | is_fence;
    opa_x = 2'b00;
    opb_x = 1'b0;
    if (is_lui) begin
      opa_x = 2'b10;
      opb_x = 1'b1;
    end else if (is_auipc | is_jal | is_branch) begin
      opa_x = 2'b01;
      opb_x = 1'b1;
    end else if (is_jalr | is_load | is_store | is_opimm) begin
      opa_x = 2'b00;
      opb_x = 1'b1;
    end
  end

  // A request is still outstanding this cycle; timeout fires once the count is exhausted
  always_comb begin
    req_wait = ((state_q == S_FETCH) && !bus.imem_ready) ||
               ((state_q == S_MEMORY) && !bus.dmem_ready);
    timeout  = TMO_EN && req_wait && (wait_q == TMO);
  end

  // State, wait counter and trap cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (req_wait && (wait_q != TMO))
        wait_q <= wait_q + 1'b1;
    end
  end

  // Next-state logic; cause only changes on the transition into TRAP
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end
      end
      S_DECODE: begin
        if (is_system) begin
          state_d = S_TRAP;
          cause_d = CAUSE_SYS;
        end else if (!legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_branch | is_fence) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (is_load | is_store) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (bus.dmem_ready) begin
          if (is_store) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath controls; operand selects stay at their EXECUTE values through
  // MEMORY and WRITEBACK so the ALU result (address / link / value) is stable
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.opa_sel  = 2'b00;
    bus.opb_sel  = 1'b0;
    bus.reg_we   = 1'b0;
    bus.wb_sel   = 2'b00;
    bus.trap     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_we    = bus.imem_ready;
      end
      S_EXECUTE: begin
        bus.opa_sel = opa_x;
        bus.opb_sel = opb_x;
        if (is_branch) begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = bus.branch_taken;
        end else if (is_fence) begin
          bus.pc_we  = 1'b1;
        end
      end
      S_MEMORY: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_store;
        bus.opa_sel  = opa_x;
        bus.opb_sel  = opb_x;
        bus.pc_we    = bus.dmem_ready & is_store;
      end
      S_WRITEBACK: begin
        bus.reg_we  = 1'b1;
        bus.pc_we   = 1'b1;
        bus.pc_sel  = is_jal | is_jalr;
        bus.opa_sel = opa_x;
        bus.opb_sel = opb_x;
        if (is_load)
          bus.wb_sel = 2'b01;
        else if (is_jal | is_jalr)
          bus.wb_sel = 2'b10;
      end
      S_TRAP:  bus.trap = 1'b1;
      default: ;
    endcase
  end

  assign bus.trap_cause = cause_q;

`ifdef RETIRE_COUNTER_EN
  logic [63:0] instret_q;

  // Count instructions leaving a completing state toward FETCH; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret_q <= 64'd0;
    else if (retire)
      instret_q <= instret_q + 64'd1;
  end

  assign bus.instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table for a
// mixed instruction stream, then hand sequences for ECALL, async reset in
// MEMORY and the fetch timeout (second instance with MEM_TIMEOUT=4).
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if u();
  multicycle_controller_if u4();

  multicycle_controller #(.MEM_TIMEOUT(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(u));
  multicycle_controller #(.MEM_TIMEOUT(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(u4));

  localparam logic [6:0] ADDI  = 7'b0010011, LW   = 7'b0000011, SW    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011, JAL  = 7'b1101111, JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111, OPR  = 7'b0110011, FENCE = 7'b0001111;
  localparam logic [6:0] ECALL = 7'b1110011, BAD  = 7'b1111111;

  // Observed bundle: {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,opa[1:0],opb,reg_we,wb[1:0],trap,cause[1:0]}
  localparam logic [14:0] Z      = 15'h0000;
  localparam logic [14:0] IMR    = 15'h4000, DMR = 15'h2000, DWE = 15'h1000, IRW = 15'h0800;
  localparam logic [14:0] PCW    = 15'h0400, PCS = 15'h0200;
  localparam logic [14:0] OPA_PC = 15'h0080, OPA_Z = 15'h0100, OPB = 15'h0040, RW = 15'h0020;
  localparam logic [14:0] WB_MEM = 15'h0008, WB_PC = 15'h0010, TRP = 15'h0004;
  localparam logic [14:0] C_ILL  = 15'h0001;
  localparam logic [14:0] FRDY   = IMR | IRW;

  typedef struct {
    logic [6:0]  op;
    logic        bt;
    logic        ir;
    logic        dr;
    logic [14:0] exp;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [14:0] obs();
    return {u.imem_req, u.dmem_req, u.dmem_we, u.ir_we, u.pc_we, u.pc_sel,
            u.opa_sel, u.opb_sel, u.reg_we, u.wb_sel, u.trap, u.trap_cause};
  endfunction

  function automatic void add(input logic [6:0] op, input logic bt, input logic ir,
                              input logic dr, input logic [14:0] e);
    vec_t v;
    v.op = op; v.bt = bt; v.ir = ir; v.dr = dr; v.exp = e;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic bt, input logic ir, input logic dr);
    u.opcode = op; u.branch_taken = bt; u.imem_ready = ir; u.dmem_ready = dr;
  endtask

  // Assert reset for a cycle and release it at a falling edge; the DUT is then in IDLE
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(ADDI, 1'b0, 1'b0, 1'b0);
    u4.opcode = ADDI; u4.branch_taken = 1'b0; u4.imem_ready = 1'b0; u4.dmem_ready = 1'b0;

    // Cycle-by-cycle stream starting in IDLE right after reset release
    add(ADDI, 1'b0, 1'b1, 1'b0, Z);                          // I
    add(ADDI, 1'b0, 1'b1, 1'b0, FRDY);                       // F
    add(ADDI, 1'b0, 1'b0, 1'b1, Z);                          // D (dmem_ready ignored)
    add(ADDI, 1'b0, 1'b0, 1'b0, OPB);                        // E rs1/imm
    add(ADDI, 1'b0, 1'b0, 1'b0, PCW | RW | OPB);             // W
    add(LW,   1'b0, 1'b1, 1'b0, FRDY);                       // F at cycle 5
    add(LW,   1'b0, 1'b0, 1'b0, Z);
    add(LW,   1'b0, 1'b0, 1'b0, OPB);
    add(LW,   1'b0, 1'b0, 1'b0, DMR | OPB);                  // M wait 1
    add(LW,   1'b0, 1'b0, 1'b0, DMR | OPB);                  // M wait 2
    add(LW,   1'b0, 1'b0, 1'b0, DMR | OPB);                  // M wait 3
    add(LW,   1'b0, 1'b0, 1'b1, DMR | OPB);                  // M ready
    add(LW,   1'b0, 1'b0, 1'b0, PCW | RW | OPB | WB_MEM);    // W load data
    add(BEQ,  1'b0, 1'b1, 1'b0, FRDY);
    add(BEQ,  1'b0, 1'b0, 1'b0, Z);
    add(BEQ,  1'b1, 1'b0, 1'b0, PCW | PCS | OPA_PC | OPB);   // E taken
    add(BEQ,  1'b0, 1'b1, 1'b0, FRDY);
    add(BEQ,  1'b0, 1'b0, 1'b0, Z);
    add(BEQ,  1'b0, 1'b0, 1'b0, PCW | OPA_PC | OPB);         // E not taken
    add(SW,   1'b0, 1'b1, 1'b0, FRDY);
    add(SW,   1'b0, 1'b0, 1'b0, Z);
    add(SW,   1'b0, 1'b0, 1'b0, OPB);
    add(SW,   1'b0, 1'b0, 1'b1, DMR | DWE | PCW | OPB);      // M store, zero wait
    add(JAL,  1'b0, 1'b1, 1'b0, FRDY);
    add(JAL,  1'b0, 1'b0, 1'b0, Z);
    add(JAL,  1'b0, 1'b0, 1'b0, OPA_PC | OPB);
    add(JAL,  1'b0, 1'b0, 1'b0, PCW | PCS | OPA_PC | OPB | RW | WB_PC);
    add(LUI,  1'b0, 1'b0, 1'b1, IMR);                        // F waiting
    add(LUI,  1'b0, 1'b1, 1'b0, FRDY);
    add(LUI,  1'b0, 1'b0, 1'b0, Z);
    add(LUI,  1'b0, 1'b0, 1'b0, OPA_Z | OPB);
    add(LUI,  1'b0, 1'b0, 1'b0, PCW | RW | OPA_Z | OPB);
    add(OPR,  1'b0, 1'b1, 1'b0, FRDY);
    add(OPR,  1'b0, 1'b0, 1'b0, Z);
    add(OPR,  1'b0, 1'b0, 1'b0, Z);                          // E rs1/rs2
    add(OPR,  1'b0, 1'b0, 1'b0, PCW | RW);
    add(FENCE,1'b0, 1'b1, 1'b0, FRDY);
    add(FENCE,1'b0, 1'b0, 1'b0, Z);
    add(FENCE,1'b0, 1'b0, 1'b0, PCW);
    add(JALR, 1'b0, 1'b1, 1'b0, FRDY);
    add(JALR, 1'b0, 1'b0, 1'b0, Z);
    add(JALR, 1'b0, 1'b0, 1'b0, OPB);
    add(JALR, 1'b0, 1'b0, 1'b0, PCW | PCS | OPB | RW | WB_PC);
    add(BAD,  1'b0, 1'b1, 1'b0, FRDY);
    add(BAD,  1'b0, 1'b0, 1'b0, Z);                          // D illegal
    add(BAD,  1'b0, 1'b1, 1'b1, TRP | C_ILL);                // TRAP, readies ignored
    add(BAD,  1'b0, 1'b1, 1'b1, TRP | C_ILL);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 64'(obs()), 64'(Z));
`ifdef RETIRE_COUNTER_EN
    chk("reset_instret", u.instret, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      if (i > 0) @(negedge clk);
      drive(tv[i].op, tv[i].bt, tv[i].ir, tv[i].dr);
      #1;
      chk($sformatf("vec%0d", i), 64'(obs()), 64'(tv[i].exp));
    end
`ifdef RETIRE_COUNTER_EN
    chk("instret_10", u.instret, 64'd10);
`endif

    // ECALL traps with cause 11; trap/cause clear on reset
    drive(ADDI, 1'b0, 1'b0, 1'b0);
    do_reset();
    #1;
    chk("cause_cleared", 64'({u.trap, u.trap_cause}), 64'd0);
    @(negedge clk); drive(ECALL, 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive(ECALL, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("ecall_trap", 64'({u.trap, u.trap_cause, u.imem_req}), 64'b1110);

    // Async reset in the middle of a load's MEMORY wait
    do_reset();
    @(negedge clk); drive(LW, 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive(LW, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("mem_req_before_rst", 64'({u.dmem_req, u.dmem_we}), 64'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mem_req_async_drop", 64'(u.dmem_req), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("restart_idle", 64'(obs()), 64'(Z));
    drive(ADDI, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("restart_fetch", 64'(u.imem_req), 64'd1);

    // MEM_TIMEOUT=4: ready arriving on the last allowed cycle wins
    do_reset();
    for (int k = 0; k < 4; k++) @(negedge clk);
    @(negedge clk); u4.imem_ready = 1'b1; #1;
    chk("tmo_ready_wins_irwe", 64'({u4.ir_we, u4.trap}), 64'b10);
    @(negedge clk); u4.imem_ready = 1'b0; #1;
    chk("tmo_ready_wins_decode", 64'({u4.imem_req, u4.trap}), 64'b00);

    // MEM_TIMEOUT=4, imem_ready stuck low: 5 FETCH cycles then TRAP cause 10
    do_reset();
    begin
      int n;
      n = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk); #1;
        if (u4.imem_req) n++;
        else break;
      end
      chk("tmo_fetch_cycles", 64'(n), 64'd5);
    end
    chk("tmo_trap", 64'({u4.trap, u4.trap_cause}), 64'b110);
    @(negedge clk); #1;
    chk("tmo_req_low", 64'({u4.imem_req, u4.trap}), 64'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
